// File: rtl/rsa_modexp_core.sv
// Modular exponentiation engine: result = base^exponent mod modulus.
// Right-to-left square-and-multiply over a shared Blakley MSB-first modular multiplier.
module rsa_modexp_core #(
    parameter int WordSize  = 16,
    parameter int ExpSize   = 16,
    parameter bit ConstTime = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WordSize-1:0] base,
    input  logic [ExpSize-1:0]  exponent,
    input  logic [WordSize-1:0] modulus,
    output logic [WordSize-1:0] result,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int CW = $clog2(WordSize);
    localparam int IW = $clog2(ExpSize + 1);

    typedef enum logic [2:0] {IDLE, LOAD, REDUCE, MUL_R, MUL_B, NEXT, DONE} state_t;

    state_t                state;
    logic [WordSize-1:0]   base_q;
    logic [ExpSize-1:0]    exp_q;
    logic [WordSize-1:0]   mod_q;
    logic [WordSize-1:0]   r_q;
    logic [WordSize-1:0]   b_q;
    logic [WordSize+1:0]   p_q;
    logic [CW-1:0]         bit_cnt;
    logic [IW-1:0]         exp_idx;
    logic                  err_q;

    logic [WordSize-1:0]   a_op;
    logic [WordSize-1:0]   b_op;
    logic                  a_bit;
    logic                  last_bit;
    logic [WordSize+1:0]   m_ext;
    logic [WordSize+1:0]   p_sum;
    logic [WordSize+1:0]   p_sub;
    logic [WordSize+1:0]   p_fin;

    // One multiplier step: P < m keeps 2P + b below 3m, so two subtractions always suffice.
    always_comb begin
        a_op = base_q;
        b_op = WordSize'(1);
        case (state)
            MUL_R: begin
                a_op = r_q;
                b_op = b_q;
            end
            MUL_B: begin
                a_op = b_q;
                b_op = b_q;
            end
            default: ;
        endcase
        a_bit    = a_op[bit_cnt];
        last_bit = (bit_cnt == '0);
        m_ext    = {2'b00, mod_q};
        p_sum    = (p_q << 1) + (a_bit ? {2'b00, b_op} : '0);
        p_sub    = (p_sum >= m_ext) ? p_sum - m_ext : p_sum;
        p_fin    = (p_sub >= m_ext) ? p_sub - m_ext : p_sub;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            base_q  <= '0;
            exp_q   <= '0;
            mod_q   <= '0;
            r_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            bit_cnt <= '0;
            exp_idx <= '0;
            err_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    base_q  <= base;
                    exp_q   <= exponent;
                    mod_q   <= modulus;
                    r_q     <= WordSize'(1);
                    p_q     <= '0;
                    bit_cnt <= CW'(WordSize - 1);
                    exp_idx <= '0;
                    err_q   <= (modulus < WordSize'(2));
                    state   <= (modulus < WordSize'(2)) ? DONE : REDUCE;
                end
                REDUCE, MUL_R, MUL_B: begin
                    if (!last_bit) begin
                        p_q     <= p_fin;
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        p_q     <= '0;
                        bit_cnt <= CW'(WordSize - 1);
                        case (state)
                            REDUCE: begin
                                b_q   <= p_fin[WordSize-1:0];
                                state <= (!ConstTime && !exp_q[0]) ? MUL_B : MUL_R;
                            end
                            MUL_R: begin
                                // In constant-time mode the product for a zero bit is simply dropped.
                                if (exp_q[0]) r_q <= p_fin[WordSize-1:0];
                                state <= MUL_B;
                            end
                            default: begin
                                b_q   <= p_fin[WordSize-1:0];
                                state <= NEXT;
                            end
                        endcase
                    end
                end
                NEXT: begin
                    exp_q <= exp_q >> 1;
                    if (exp_idx == IW'(ExpSize - 1)) begin
                        state <= DONE;
                    end else begin
                        exp_idx <= exp_idx + 1'b1;
                        state   <= (!ConstTime && !exp_q[1]) ? MUL_B : MUL_R;
                    end
                end
                DONE: begin
                    result <= err_q ? '0 : r_q;
                    done   <= 1'b1;
                    err    <= err_q;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Self-checking bench for rsa_modexp_core: a 16/16 constant-time instance plus 8/8 instances
// in both timing modes, checked against a plain-arithmetic reference model.
module tb_rsa_modexp_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [15:0] base_v;
    logic [15:0] exp_v;
    logic [15:0] mod_v;
    logic [15:0] res16;
    logic [7:0]  res8c;
    logic [7:0]  res8v;
    logic [2:0]  done_v;
    logic [2:0]  busy_v;
    logic [2:0]  err_v;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    rsa_modexp_core #(.WordSize(16), .ExpSize(16), .ConstTime(1'b1)) dut16 (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .base(base_v), .exponent(exp_v), .modulus(mod_v),
        .result(res16), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0])
    );

    rsa_modexp_core #(.WordSize(8), .ExpSize(8), .ConstTime(1'b1)) dut8c (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .base(base_v[7:0]), .exponent(exp_v[7:0]), .modulus(mod_v[7:0]),
        .result(res8c), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1])
    );

    rsa_modexp_core #(.WordSize(8), .ExpSize(8), .ConstTime(1'b0)) dut8v (
        .clk(clk), .reset(reset), .start(start_v[2]),
        .base(base_v[7:0]), .exponent(exp_v[7:0]), .modulus(mod_v[7:0]),
        .result(res8v), .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_compared++;
        if (obs !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_modexp(input longint unsigned b, input longint unsigned e,
                                               input longint unsigned m, input int ebits);
        longint unsigned r = 1;
        longint unsigned bb = b % m;
        for (int i = 0; i < ebits; i++) begin
            if (((e >> i) & 1) == 1) r = (r * bb) % m;
            bb = (bb * bb) % m;
        end
        return 32'(r);
    endfunction

    function automatic int ref_latency(input int w, input int ebits, input bit ct,
                                       input logic [15:0] e, input logic [15:0] m);
        int n;
        if (m < 2) return 2;
        n = 2 + w;
        for (int i = 0; i < ebits; i++) n += (ct || e[i]) ? (2 * w + 1) : (w + 1);
        return n;
    endfunction

    function automatic logic [15:0] res_of(input int sel);
        if (sel == 0) return res16;
        if (sel == 1) return {8'h00, res8c};
        return {8'h00, res8v};
    endfunction

    task automatic applyStimulus(input int sel, input logic [15:0] b, input logic [15:0] e,
                                 input logic [15:0] m, input bit poke, input int known);
        int          w;
        int          cycles;
        logic [15:0] mask;
        logic [15:0] bm, em, mm;
        logic [31:0] exp_res;
        int          exp_lat;
        bit          is_err;
        w       = (sel == 0) ? 16 : 8;
        mask    = (sel == 0) ? 16'hFFFF : 16'h00FF;
        bm      = b & mask;
        em      = e & mask;
        mm      = m & mask;
        is_err  = (mm < 2);
        exp_res = is_err ? 32'd0 : ref_modexp(64'(bm), 64'(em), 64'(mm), w);
        exp_lat = ref_latency(w, w, sel != 2, em, mm);

        @(negedge clk);
        base_v       = b;
        exp_v        = e;
        mod_v        = m;
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        cycles       = 0;
        checkOutput("busy_after_accept", 32'(busy_v[sel]), 32'd1);
        while (done_v[sel] !== 1'b1 && cycles < 4000) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) begin
                base_v = 16'($urandom);
                exp_v  = 16'($urandom);
                mod_v  = 16'($urandom);
            end
            if (poke && cycles == 40) start_v[sel] = 1'b1;
            if (poke && cycles == 41) start_v[sel] = 1'b0;
        end
        checkOutput("done_seen", 32'(done_v[sel]), 32'd1);
        checkOutput("latency", 32'(cycles), 32'(exp_lat));
        checkOutput("result", 32'(res_of(sel)), exp_res);
        checkOutput("err_flag", 32'(err_v[sel]), 32'(is_err));
        checkOutput("busy_at_done", 32'(busy_v[sel]), 32'd0);
        if (known >= 0) checkOutput("known_result", 32'(res_of(sel)), 32'(known));
        @(posedge clk); #1;
        checkOutput("done_pulse_width", 32'(done_v[sel]), 32'd0);
        checkOutput("err_pulse_width", 32'(err_v[sel]), 32'd0);
        checkOutput("result_held", 32'(res_of(sel)), exp_res);
    endtask

    initial begin
        #700000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int seen_done;
        logic [15:0] rb, re, rm;
        reset   = 1'b1;
        start_v = '0;
        base_v  = '0;
        exp_v   = '0;
        mod_v   = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            checkOutput("reset_result", 32'(res_of(s)), 32'd0);
            checkOutput("reset_busy", 32'(busy_v[s]), 32'd0);
            checkOutput("reset_done", 32'(done_v[s]), 32'd0);
            checkOutput("reset_err", 32'(err_v[s]), 32'd0);
        end
        reset = 1'b0;

        applyStimulus(0, 16'd4, 16'd13, 16'd497, 1'b0, 445);
        applyStimulus(0, 16'd2, 16'd7, 16'd33, 1'b0, 29);
        applyStimulus(0, 16'd29, 16'd3, 16'd33, 1'b0, 2);
        applyStimulus(0, 16'd9, 16'd5, 16'd1, 1'b0, 0);
        applyStimulus(0, 16'd100, 16'd1, 16'd33, 1'b0, 1);
        applyStimulus(0, 16'd7, 16'd0, 16'd33, 1'b0, 1);
        applyStimulus(0, 16'd65534, 16'd2, 16'd65535, 1'b0, 1);
        applyStimulus(0, 16'd0, 16'd9, 16'd97, 1'b0, 0);
        applyStimulus(0, 16'd4, 16'd13, 16'd497, 1'b1, 445);

        applyStimulus(1, 16'd5, 16'h00, 16'd77, 1'b0, 1);
        applyStimulus(1, 16'd5, 16'hFF, 16'd77, 1'b0, -1);
        applyStimulus(2, 16'd5, 16'h00, 16'd77, 1'b0, 1);
        applyStimulus(2, 16'd5, 16'hFF, 16'd77, 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            rb = 16'($urandom);
            re = 16'($urandom);
            rm = (i == 3) ? 16'($urandom_range(0, 1)) :
                 (i == 5) ? 16'hFFFF : 16'($urandom_range(2, 65535));
            applyStimulus(0, rb, re, rm, 1'b0, -1);
        end
        for (int i = 0; i < 8; i++) begin
            rb = 16'($urandom);
            re = 16'($urandom);
            rm = 16'($urandom_range(2, 255));
            applyStimulus(1 + (i % 2), rb, re, rm, 1'b0, -1);
        end

        // Abort a computation while the first squaring is under way.
        @(negedge clk);
        base_v     = 16'd1234;
        exp_v      = 16'd4321;
        mod_v      = 16'd40000;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_busy", 32'(busy_v[0]), 32'd0);
        checkOutput("abort_result", 32'(res16), 32'd0);
        checkOutput("abort_done", 32'(done_v[0]), 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        seen_done = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (done_v[0] === 1'b1) seen_done++;
        end
        checkOutput("no_done_after_abort", 32'(seen_done), 32'd0);
        applyStimulus(0, 16'd2, 16'd7, 16'd33, 1'b0, 29);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
